// File: rtl/mr_pkg.sv
// Shared types and helpers for the Miller-Rabin tester: FSM encoding, small-prime constants, witness mapping.
package mr_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CHECK   = 3'd1,
      DECOMP  = 3'd2,
      GET_WIT = 3'd3,
      EXP     = 3'd4,
      TEST    = 3'd5,
      SQUARE  = 3'd6,
      DONE    = 3'd7
   } state_t;

   localparam int unsigned MR_FAST_TWO   = 2;
   localparam int unsigned MR_FAST_THREE = 3;

   // Helper operates at this fixed width; callers zero-extend and truncate (NUM_BITS must not exceed it).
   localparam int MR_MAX_BITS = 256;

   // Maps a raw random word onto a witness in [2, n-2]. The zero-span guard only matters for
   // n==3, which never reaches witness selection.
   function automatic logic [MR_MAX_BITS-1:0] mr_witness(input logic [MR_MAX_BITS-1:0] w,
                                                         input logic [MR_MAX_BITS-1:0] n);
      logic [MR_MAX_BITS-1:0] span;
      span = n - MR_MAX_BITS'(MR_FAST_THREE);
      if (span == '0)
         return MR_MAX_BITS'(MR_FAST_TWO);
      return MR_MAX_BITS'(MR_FAST_TWO) + (w % span);
   endfunction

endpackage

// File: rtl/mod_exp_unit.sv
// Sequential base^exp mod modulus, MSB-first square-and-multiply, one exponent bit per cycle.
// done pulses exactly NUM_BITS+1 cycles after start; operands are captured on start.
module mod_exp_unit #(
   parameter int NUM_BITS = 128
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                start,
   input  logic [NUM_BITS-1:0] base,
   input  logic [NUM_BITS-1:0] exp,
   input  logic [NUM_BITS-1:0] modulus,
   output logic                done,
   output logic [NUM_BITS-1:0] result
);
   localparam int CW = $clog2(NUM_BITS + 1);
   localparam int PW = 2 * NUM_BITS;

   logic [NUM_BITS-1:0] base_q, exp_q, mod_q, acc_q;
   logic [NUM_BITS-1:0] sq_red, mul_red, acc_nxt;
   logic [CW-1:0]       bits_left;
   logic                busy;

   always_comb begin
      sq_red  = NUM_BITS'((PW'(acc_q) * PW'(acc_q)) % PW'(mod_q));
      mul_red = NUM_BITS'((PW'(sq_red) * PW'(base_q)) % PW'(mod_q));
      acc_nxt = exp_q[NUM_BITS-1] ? mul_red : sq_red;
   end

   // Every exponent bit is scanned, leading zeros included, so latency does not depend on exp.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         bits_left <= '0;
         base_q    <= '0;
         exp_q     <= '0;
         mod_q     <= '0;
         acc_q     <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            base_q    <= base;
            exp_q     <= exp;
            mod_q     <= modulus;
            acc_q     <= NUM_BITS'(1);
            bits_left <= CW'(NUM_BITS);
            busy      <= 1'b1;
         end else if (busy) begin
            acc_q     <= acc_nxt;
            exp_q     <= exp_q << 1;
            bits_left <= bits_left - CW'(1);
            if (bits_left == CW'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign result = acc_q;

endmodule

// File: rtl/miller_rabin_tester.sv
// Miller-Rabin tester: candidate in, witnesses pulled per round, verdict out with early exit on composite.
// Fast paths answer 2 cycles after accept; GET_WIT and DONE wait indefinitely on their handshakes.
module miller_rabin_tester
   import mr_pkg::*;
#(
   parameter int NUM_BITS = 128,
   parameter int ROUNDS   = 10,
   parameter int RND_W    = $clog2(ROUNDS + 1)
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                cand_valid,
   output logic                cand_ready,
   input  logic [NUM_BITS-1:0] cand_data,
   input  logic                wit_valid,
   output logic                wit_ready,
   input  logic [NUM_BITS-1:0] wit_data,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [NUM_BITS-1:0] res_data,
   output logic                res_prime,
   output logic [RND_W-1:0]    res_rounds
);
   localparam int SW = $clog2(NUM_BITS);
   localparam int PW = 2 * NUM_BITS;

   state_t              state, state_nxt;
   logic                live;
   logic [NUM_BITS-1:0] n_q, nm1_q, d_q, x_q, x_sq, wit_a, exp_result;
   logic [SW-1:0]       s_q, j_q;
   logic [RND_W-1:0]    rounds_q, rounds_inc;
   logic                exp_start, exp_done;
   logic                round_pass, verdict, verdict_prime;

   assign x_sq       = NUM_BITS'((PW'(x_q) * PW'(x_q)) % PW'(n_q));
   assign wit_a      = NUM_BITS'(mr_witness(MR_MAX_BITS'(wit_data), MR_MAX_BITS'(n_q)));
   assign rounds_inc = rounds_q + RND_W'(1);

   mod_exp_unit #(.NUM_BITS(NUM_BITS)) u_exp (
      .aclk    (aclk),
      .aresetn (aresetn),
      .start   (exp_start),
      .base    (wit_a),
      .exp     (d_q),
      .modulus (n_q),
      .done    (exp_done),
      .result  (exp_result)
   );

   always_ff @(posedge aclk) begin
      if (!aresetn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      cand_ready    = 1'b0;
      wit_ready     = 1'b0;
      res_valid     = 1'b0;
      exp_start     = 1'b0;
      round_pass    = 1'b0;
      verdict       = 1'b0;
      verdict_prime = 1'b0;
      unique case (state)
         IDLE: begin
            // live holds cand_ready low for the first cycle after reset release
            cand_ready = live;
            if (live && cand_valid)
               state_nxt = CHECK;
         end
         CHECK: begin
            if (n_q < NUM_BITS'(MR_FAST_TWO)) begin
               verdict = 1'b1;
            end else if (n_q == NUM_BITS'(MR_FAST_TWO) || n_q == NUM_BITS'(MR_FAST_THREE)) begin
               verdict       = 1'b1;
               verdict_prime = 1'b1;
            end else if (!n_q[0]) begin
               verdict = 1'b1;
            end else begin
               state_nxt = DECOMP;
            end
         end
         // d enters even; leave on the shift that makes it odd so DECOMP lasts exactly s cycles
         DECOMP: if (d_q[1]) state_nxt = GET_WIT;
         GET_WIT: begin
            wit_ready = 1'b1;
            if (wit_valid) begin
               exp_start = 1'b1;
               state_nxt = EXP;
            end
         end
         EXP: if (exp_done) state_nxt = TEST;
         TEST: begin
            if (x_q == NUM_BITS'(1) || x_q == nm1_q)
               round_pass = 1'b1;
            else if (j_q < s_q)
               state_nxt = SQUARE;
            else
               verdict = 1'b1;
         end
         SQUARE: begin
            if (x_sq == nm1_q)
               round_pass = 1'b1;
            else if (x_sq == NUM_BITS'(1))
               verdict = 1'b1;
            else
               state_nxt = TEST;
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (round_pass) begin
         if (rounds_inc == RND_W'(ROUNDS)) begin
            verdict       = 1'b1;
            verdict_prime = 1'b1;
         end else begin
            state_nxt = GET_WIT;
         end
      end
      if (verdict)
         state_nxt = DONE;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         live       <= 1'b0;
         n_q        <= '0;
         nm1_q      <= '0;
         d_q        <= '0;
         x_q        <= '0;
         s_q        <= '0;
         j_q        <= '0;
         rounds_q   <= '0;
         res_data   <= '0;
         res_prime  <= 1'b0;
         res_rounds <= '0;
      end else begin
         live <= 1'b1;
         if (cand_ready && cand_valid) begin
            n_q      <= cand_data;
            rounds_q <= '0;
         end
         if (state == CHECK) begin
            d_q   <= n_q - NUM_BITS'(1);
            nm1_q <= n_q - NUM_BITS'(1);
            s_q   <= '0;
         end
         if (state == DECOMP) begin
            d_q <= d_q >> 1;
            s_q <= s_q + SW'(1);
         end
         if (state == EXP && exp_done) begin
            x_q <= exp_result;
            j_q <= SW'(1);
         end
         if (state == SQUARE) begin
            x_q <= x_sq;
            j_q <= j_q + SW'(1);
         end
         if (round_pass)
            rounds_q <= rounds_inc;
         if (verdict) begin
            res_data   <= n_q;
            res_prime  <= verdict_prime;
            res_rounds <= round_pass ? rounds_inc : rounds_q;
         end
      end
   end

endmodule

// File: tb/tb_miller_rabin_tester.sv
// Directed bench: main instance (128 bits, 10 rounds) plus a 4-round instance sharing data buses.
module tb_miller_rabin_tester;

   logic         aclk = 1'b0;
   logic         aresetn;
   logic [127:0] cand_data, wit_data;
   logic         res_ready;

   logic         cand_valid, cand_ready, wit_valid, wit_ready, res_valid, res_prime;
   logic [127:0] res_data;
   logic [3:0]   res_rounds;

   logic         s_cand_valid, s_cand_ready, s_wit_valid, s_wit_ready, s_res_valid, s_res_prime;
   logic [127:0] s_res_data;
   logic [2:0]   s_res_rounds;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int hs;
   int hs_cyc[$];
   logic [127:0] wq[$];

   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;

   miller_rabin_tester #(.NUM_BITS(128), .ROUNDS(10)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_data(cand_data),
      .wit_valid(wit_valid), .wit_ready(wit_ready), .wit_data(wit_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_prime(res_prime), .res_rounds(res_rounds)
   );

   miller_rabin_tester #(.NUM_BITS(128), .ROUNDS(4)) dut_small (
      .aclk(aclk), .aresetn(aresetn),
      .cand_valid(s_cand_valid), .cand_ready(s_cand_ready), .cand_data(cand_data),
      .wit_valid(s_wit_valid), .wit_ready(s_wit_ready), .wit_data(wit_data),
      .res_valid(s_res_valid), .res_ready(res_ready), .res_data(s_res_data),
      .res_prime(s_res_prime), .res_rounds(s_res_rounds)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   function automatic logic cr(input bit sm); return sm ? s_cand_ready : cand_ready; endfunction
   function automatic logic wr(input bit sm); return sm ? s_wit_ready : wit_ready; endfunction
   function automatic logic rv(input bit sm); return sm ? s_res_valid : res_valid; endfunction
   function automatic logic rp(input bit sm); return sm ? s_res_prime : res_prime; endfunction
   function automatic logic [127:0] rd(input bit sm); return sm ? s_res_data : res_data; endfunction
   function automatic logic [3:0] rr(input bit sm);
      return sm ? {1'b0, s_res_rounds} : res_rounds;
   endfunction

   task automatic set_cv(input bit sm, input logic v);
      if (sm) s_cand_valid = v; else cand_valid = v;
   endtask
   task automatic set_wv(input bit sm, input logic v);
      if (sm) s_wit_valid = v; else wit_valid = v;
   endtask

   // Returns one cycle after the accepting edge (cycle T+1).
   task automatic offer_cand(input bit sm, input logic [127:0] n);
      int k = 0;
      cand_data = n;
      set_cv(sm, 1'b1);
      while (!cr(sm) && k < 100) begin
         step();
         k++;
      end
      check("cand_accept", 128'(cr(sm)), 128'(1));
      step();
      set_cv(sm, 1'b0);
   endtask

   // Feeds witnesses from wq (cyclically) until a verdict, recording handshake cycles.
   task automatic run_wits(input bit sm, input int limit);
      hs = 0;
      hs_cyc.delete();
      set_wv(sm, 1'b1);
      for (int k = 0; k < limit && !rv(sm); k++) begin
         wit_data = wq[hs % wq.size()];
         if (wr(sm)) begin
            hs_cyc.push_back(cyc);
            hs++;
         end
         step();
      end
      set_wv(sm, 1'b0);
      check("verdict_reached", 128'(rv(sm)), 128'(1));
   endtask

   task automatic take_result(input bit sm);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check("res_valid_after_hs", 128'(rv(sm)), 128'(0));
      check("cand_ready_after_hs", 128'(cr(sm)), 128'(1));
   endtask

   task automatic fast_path(input logic [127:0] n, input logic prime);
      offer_cand(1'b0, n);
      check("fast_t1_res_valid", 128'(res_valid), 128'(0));
      check("fast_t1_wit_ready", 128'(wit_ready), 128'(0));
      step();
      check("fast_t2_res_valid", 128'(res_valid), 128'(1));
      check("fast_prime", 128'(res_prime), 128'(prime));
      check("fast_rounds", 128'(res_rounds), 128'(0));
      check("fast_data", res_data, n);
      check("fast_wit_ready", 128'(wit_ready), 128'(0));
   endtask

   initial begin
      logic [127:0] m127;
      logic         ok;
      int           k;

      aresetn = 1'b0;
      cand_valid = 1'b0; wit_valid = 1'b0; s_cand_valid = 1'b0; s_wit_valid = 1'b0;
      res_ready = 1'b0; cand_data = '0; wit_data = '0;
      m127 = (128'd1 << 127) - 128'd1;

      repeat (3) step();
      check("rst_cand_ready", 128'(cand_ready), 128'(0));
      check("rst_wit_ready", 128'(wit_ready), 128'(0));
      check("rst_res_valid", 128'(res_valid), 128'(0));
      check("rst_res_data", res_data, 128'(0));
      check("rst_res_prime", 128'(res_prime), 128'(0));
      check("rst_res_rounds", 128'(res_rounds), 128'(0));
      aresetn = 1'b1;
      check("rst_release_cand_ready_low", 128'(cand_ready), 128'(0));
      step();
      check("cand_ready_rises", 128'(cand_ready), 128'(1));
      check("small_cand_ready_rises", 128'(s_cand_ready), 128'(1));

      fast_path(128'd0, 1'b0);   take_result(1'b0);
      fast_path(128'd1, 1'b0);   take_result(1'b0);
      fast_path(128'd2, 1'b1);   take_result(1'b0);
      fast_path(128'd3, 1'b1);   take_result(1'b0);
      fast_path(128'd100, 1'b0);

      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!(res_valid && res_data == 128'd100 && !res_prime && res_rounds == 4'd0 &&
               !cand_ready && !wit_ready))
            ok = 1'b0;
      end
      check("hold_stable_20", 128'(ok), 128'(1));
      take_result(1'b0);

      // 561 = 35 * 2^4 + 1: witness wanted 2 + s = 6 cycles after accept
      offer_cand(1'b0, 128'd561);
      repeat (4) step();
      check("decomp_t5_wit_ready", 128'(wit_ready), 128'(0));
      step();
      check("decomp_t6_wit_ready", 128'(wit_ready), 128'(1));
      repeat (15) step();
      check("stall_wit_ready", 128'(wit_ready), 128'(1));
      check("stall_res_valid", 128'(res_valid), 128'(0));
      wq.delete(); wq.push_back(128'd0);
      run_wits(1'b0, 500);
      check("c561_handshakes", 128'(hs), 128'(1));
      check("c561_prime", 128'(res_prime), 128'(0));
      check("c561_rounds", 128'(res_rounds), 128'(0));
      check("c561_data", res_data, 128'd561);
      take_result(1'b0);

      // Mersenne prime: s=1, each round is wit handshake + 129 EXP cycles + TEST
      offer_cand(1'b0, m127);
      wq.delete();
      for (int i = 0; i < 10; i++)
         wq.push_back(128'(i) * 128'h9E3779B97F4A7C15 + 128'd17);
      run_wits(1'b0, 2000);
      check("m127_handshakes", 128'(hs), 128'(10));
      check("m127_prime", 128'(res_prime), 128'(1));
      check("m127_rounds", 128'(res_rounds), 128'(10));
      check("m127_data", res_data, m127);
      for (int i = 1; i < hs_cyc.size(); i++)
         check("m127_round_period", 128'(hs_cyc[i] - hs_cyc[i-1]), 128'(131));
      take_result(1'b0);

      // Reset in the middle of exponentiation, with a witness offered in the reset cycle
      offer_cand(1'b0, m127);
      k = 0;
      while (!wit_ready && k < 50) begin
         step();
         k++;
      end
      check("rst_exp_wit_ready", 128'(wit_ready), 128'(1));
      wit_data = 128'd5;
      wit_valid = 1'b1;
      step();
      wit_valid = 1'b0;
      repeat (40) step();
      check("rst_exp_busy_no_verdict", 128'(res_valid), 128'(0));
      wit_valid = 1'b1;
      aresetn = 1'b0;
      step();
      wit_valid = 1'b0;
      check("midrst_cand_ready", 128'(cand_ready), 128'(0));
      check("midrst_wit_ready", 128'(wit_ready), 128'(0));
      check("midrst_res_valid", 128'(res_valid), 128'(0));
      check("midrst_res_data", res_data, 128'(0));
      check("midrst_res_prime", 128'(res_prime), 128'(0));
      check("midrst_res_rounds", 128'(res_rounds), 128'(0));
      aresetn = 1'b1;
      step();
      check("midrst_cand_ready_back", 128'(cand_ready), 128'(1));
      check("midrst_no_verdict", 128'(res_valid), 128'(0));

      // n=9: a=2, x runs 2 -> 4 -> 7 and never hits 8
      offer_cand(1'b0, 128'd9);
      wq.delete(); wq.push_back(128'd0);
      run_wits(1'b0, 500);
      check("c9_handshakes", 128'(hs), 128'(1));
      check("c9_prime", 128'(res_prime), 128'(0));
      check("c9_rounds", 128'(res_rounds), 128'(0));
      check("c9_data", res_data, 128'd9);
      take_result(1'b0);

      // n=13 on the 4-round instance: witnesses map to a = 2, 3, 7, 11
      offer_cand(1'b1, 128'd13);
      wq.delete();
      wq.push_back(128'd0); wq.push_back(128'd1); wq.push_back(128'd5); wq.push_back(128'd9);
      run_wits(1'b1, 1000);
      check("p13_handshakes", 128'(hs), 128'(4));
      check("p13_prime", 128'(rp(1'b1)), 128'(1));
      check("p13_rounds", 128'(rr(1'b1)), 128'(4));
      check("p13_data", rd(1'b1), 128'd13);
      check("p13_main_idle", 128'(res_valid), 128'(0));
      take_result(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
